// File: rtl/mux2_rr_sel_ctrl_pkg.sv
// mux2_rr_sel_ctrl_pkg: arbiter state encoding and select constants
package mux2_rr_sel_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_e;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux2_rr_sel_ctrl.sv
// mux2_rr_sel_ctrl: round-robin burst arbiter over sources A/B (req/data/last in, ack out) driving select s and a one-deep output register (o, o_valid, o_last, o_src, o_ready)
module mux2_rr_sel_ctrl
  import mux2_rr_sel_ctrl_pkg::*;
#(
  parameter int W = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ack,
  input  logic         b_req,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ack,
  output logic         s,
  output logic [W-1:0] o,
  output logic         o_valid,
  output logic         o_last,
  output logic         o_src,
  input  logic         o_ready
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
  state_e state_q, state_d;
  logic ptr_q, ptr_d, s_q, s_d, o_valid_q, o_valid_d, o_last_q, o_last_d, o_src_q, o_src_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] o_q, o_d, in_data;
  logic ld, req, gnt_b, xfer, eob, in_last;
  assign ld = !o_valid_q || o_ready;
  assign a_ack = state_q == GNT_A && ld;
  assign b_ack = state_q == GNT_B && ld;
  assign xfer = (a_req && a_ack) || (b_req && b_ack);
  // s is already valid in every grant cycle, so it steers the input side too
  assign in_data = s_q ? b_data : a_data;
  assign in_last = s_q ? b_last : a_last;
  assign eob = xfer && (in_last || cnt_q + CW'(1) == CMAX);
  assign req = a_req || b_req;
  assign gnt_b = b_req && (!a_req || ptr_q == SEL_B);
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      state_d = req ? (gnt_b ? GNT_B : GNT_A) : IDLE;
      s_d = req ? gnt_b : s_q;
    end else if (xfer) begin
      state_d = eob ? IDLE : state_q;
      cnt_d = eob ? '0 : cnt_q + CW'(1);
      ptr_d = eob ? (s_q ? SEL_A : SEL_B) : ptr_q;
    end
    o_d = xfer ? in_data : o_q;
    o_last_d = xfer ? in_last : o_last_q;
    o_src_d = xfer ? s_q : o_src_q;
    o_valid_d = xfer || (o_valid_q && !o_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= SEL_A;
      ptr_q <= SEL_A;
      cnt_q <= '0;
      o_q <= '0;
      o_valid_q <= 1'b0;
      o_last_q <= 1'b0;
      o_src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      o_q <= o_d;
      o_valid_q <= o_valid_d;
      o_last_q <= o_last_d;
      o_src_q <= o_src_d;
    end
  end
  assign s = s_q;
  assign o = o_q;
  assign o_valid = o_valid_q;
  assign o_last = o_last_q;
  assign o_src = o_src_q;
endmodule

// File: doc/mux2_rr_sel_ctrl.md
Name: mux2_rr_sel_ctrl

Overview:
- Upstream control stage for the 2:1 select datapath. Arbitrates between two valid/ready sources, A and B, using round-robin priority.
- Drives the registered select line `s`, which steers the downstream 2:1 mux, and also forwards the granted source's data through a one-deep output register with backpressure.
- Grants are burst-based: a grant is held until the source marks its last beat, or until MAX_BURST beats have transferred.

Parameters:
- W, 8, data width of each source and of the output.
- MAX_BURST, 4, maximum beats per grant before forced release; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  source A word valid.
- a_data  in  W  source A word.
- a_last  in  1  source A final beat of packet.
- a_ack  out  1  source A ready; a beat transfers when a_req && a_ack.
- b_req  in  1  source B word valid.
- b_data  in  W  source B word.
- b_last  in  1  source B final beat of packet.
- b_ack  out  1  source B ready.
- s  out  1  registered mux select; 0 = A, 1 = B.
- o  out  W  registered output word.
- o_valid  out  1  output word valid.
- o_last  out  1  output word is the source's last beat.
- o_src  out  1  source of the current output word; 0 = A, 1 = B.
- o_ready  in  1  downstream ready; output beat consumed when o_valid && o_ready.

Behaviour:
- Reset values: s=0, o=0, o_valid=0, o_last=0, o_src=0, a_ack=0, b_ack=0. State is IDLE, the priority pointer is 0 (A first), and the beat counter is 0.
- States:
  - IDLE: no grant. a_ack = b_ack = 0.
  - GNT_A: A is granted.
  - GNT_B: B is granted.
- IDLE transitions:
  - Only a_req -> GNT_A. Only b_req -> GNT_B.
  - Both requesting -> grant goes to the pointer's side.
  - Neither requesting -> stay in IDLE.
  - s is updated in the same clock edge as the transition, so s is valid in the first GNT cycle. In IDLE, s holds its previous value.
- Grant latency: a request seen in IDLE is acked at the earliest in the next cycle.
- Acceptance: the output register can load when `ld = !o_valid || o_ready`.
  - In GNT_A, a_ack = ld; b_ack = 0. GNT_B mirrors this.
  - The ack is combinational from state, o_valid and o_ready; it never depends on req.
- On a transfer:
  - o, o_last and o_src load from the granted source; o_valid is set to 1; the beat counter increments.
  - Data appears on o one cycle after the transfer.
- End of burst, on a transferring beat with last=1 or counter+1 == MAX_BURST:
  - Next state is IDLE.
  - Counter clears.
  - Pointer is set to the opposite side of the source just served.
  - An IDLE bubble cycle always follows, even if the same source keeps requesting.
- Forced release at MAX_BURST does not set o_last. o_last reflects only the source's last input.
- req low while granted: no transfer occurs, the grant is held, and there is no timeout.
- Output register with no new load: if o_valid && o_ready, o_valid clears to 0 and o holds its value. With o_valid && !o_ready, all output fields hold stable.
- Simultaneous o_ready and a new transfer in the same cycle: the new word replaces the old one and o_valid stays 1. No bubble is inserted.
- Reset mid-burst: the next edge restores all reset values. A partial packet and any pending output word are discarded with no o_last.
- Counter width is clog2(MAX_BURST+1). With MAX_BURST=1, every beat ends the grant.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2.
  - SEL_A=1'b0, SEL_B=1'b1.
- No sub-module is required. Optionally, the 2:1 data steering can instantiate the existing 2:1 mux cell bit-wise, driven by s.

Test Plan:
1. Reset and single source:
   - Stimulus: assert rst for 2 cycles, then a_req=1 with a_data 0x11, 0x22 (last on 0x22), o_ready=1.
   - Required response: a_ack rises in cycle 2 after req. o shows 0x11 then 0x22, with o_last only on 0x22. s=0 throughout. State returns to IDLE.
2. Contention and fairness:
   - Stimulus: a_req and b_req held continuously, 1-beat packets (last=1), o_ready=1.
   - Required response: o_src alternates A, B, A, B, starting with A. s toggles accordingly, with an IDLE bubble between grants.
3. Burst cap:
   - Stimulus: MAX_BURST=4, B sends 6 beats 0x01..0x06 with last on 0x06, A idle.
   - Required response: the first grant carries 0x01..0x04 with o_last=0. After the bubble, B is re-granted for 0x05..0x06, with o_last on 0x06.
4. Backpressure:
   - Stimulus: o_ready=0 while the output word is 0x33.
   - Required response: o stays 0x33 with o_valid=1, a_ack=0, and no beat is lost. When o_ready rises, the next word loads in the same cycle.
5. Requester gap:
   - Stimulus: A is granted, then a_req drops for 3 cycles mid-packet.
   - Required response: the grant is held, s is unchanged, and b_req is ignored until A's last beat.
6. Reset mid-burst:
   - Stimulus: rst asserted after 2 of 4 beats, with o_valid=1.
   - Required response: the next cycle shows o_valid=0, acks 0, s=0. The following arbitration starts from the A-first pointer.
